ring_vco_freq_counter: RTL and testbench



---
 rtl/ring_vco_pkg.sv | 25 ++
 rtl/osc_edge_sync.sv | 27 ++
 rtl/ring_vco_freq_counter.sv | 157 +++++++++++++++
 tb/tb_ring_vco_freq_counter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ring_vco_pkg.sv
// Shared types and defaults for the ring VCO frequency read-out and its helpers.
package ring_vco_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SETTLE = 3'd2,
        COUNT  = 3'd3,
        DONE   = 3'd4
    } vcoState_e;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_WIN_W         = 16;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_INIT_CYCLES   = 16;
    localparam int DEF_SETTLE_CYCLES = 64;

    // Saturation value of the edge counter at its default width.
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Brings an asynchronous oscillator into the clk domain and emits a one-cycle
// pulse for every rising edge seen after synchronization.
module osc_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic osc_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], osc_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_vco_freq_counter.sv
// Kick-starts the ring VCO, waits for it to settle, counts osc rising edges over
// a programmable window and posts the result through a valid/ready handshake.
module ring_vco_freq_counter
    import ring_vco_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WIN_W         = DEF_WIN_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int INIT_CYCLES   = DEF_INIT_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             osc,
    output logic             vinit,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overflow
);

    // One timer serves the kick-start, settle and window phases.
    localparam int TMR_W = maxInt(WIN_W, maxInt($clog2(INIT_CYCLES), $clog2(SETTLE_CYCLES)));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    vcoState_e         state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [WIN_W-1:0]  winLen_q, winLen_d;
    logic [CNT_W-1:0]  edgeCnt_q, edgeCnt_d;
    logic              ovfFlag_q, ovfFlag_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              countValid_q, countValid_d;
    logic              busy_q, busy_d;
    logic              vinit_q, vinit_d;
    logic              oscRise;

    osc_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_osc_sync (
        .clk    (clk),
        .rst    (rst),
        .osc_i  (osc),
        .rise_o (oscRise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            winLen_q     <= '0;
            edgeCnt_q    <= '0;
            ovfFlag_q    <= 1'b0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            countValid_q <= 1'b0;
            busy_q       <= 1'b0;
            vinit_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            winLen_q     <= winLen_d;
            edgeCnt_q    <= edgeCnt_d;
            ovfFlag_q    <= ovfFlag_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            countValid_q <= countValid_d;
            busy_q       <= busy_d;
            vinit_q      <= vinit_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        winLen_d     = winLen_q;
        edgeCnt_d    = edgeCnt_q;
        ovfFlag_d    = ovfFlag_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        countValid_d = countValid_q;

        if (countValid_q && count_ready) begin
            countValid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    winLen_d     = win_len;
                    countValid_d = 1'b0;
                    timer_d      = TMR_W'(INIT_CYCLES - 1);
                    state_d      = INIT;
                end
            end
            INIT: begin
                if (timer_q == '0) begin
                    timer_d = TMR_W'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            SETTLE: begin
                edgeCnt_d = '0;
                ovfFlag_d = 1'b0;
                if (timer_q == '0) begin
                    if (winLen_q == '0) begin
                        state_d = DONE;
                    end else begin
                        timer_d = TMR_W'(winLen_q) - TMR_W'(1);
                        state_d = COUNT;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            COUNT: begin
                if (oscRise) begin
                    if (edgeCnt_q == CNT_MAX) begin
                        ovfFlag_d = 1'b1;
                    end else begin
                        edgeCnt_d = edgeCnt_q + CNT_W'(1);
                    end
                end
                if (timer_q == '0) begin
                    state_d = DONE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            DONE: begin
                count_d      = edgeCnt_q;
                overflow_d   = ovfFlag_q;
                countValid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so they align with it.
        vinit_d = (state_d != INIT);
        busy_d  = (state_d != IDLE);
    end

    assign vinit       = vinit_q;
    assign busy        = busy_q;
    assign count       = count_q;
    assign count_valid = countValid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ring_vco_freq_counter.sv
// Randomized self-checking bench: osc edges are logged by cycle and the expected
// count is the number of edges whose synchronized detection lands in the window.
module tb_ring_vco_freq_counter;

    localparam int INIT_C   = 16;
    localparam int SETTLE_C = 64;
    localparam int SYNC_S   = 2;
    localparam int SAT_MAX  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        osc = 1'b0;
    logic        countReady = 1'b0;
    logic [15:0] winLen = '0;

    logic        vinit, busy, countValid, overflow;
    logic [15:0] count;
    logic        vinitS, busyS, countValidS, overflowS;
    logic [3:0]  countS;

    int checkCnt = 0;
    int errCnt = 0;
    int cycNum = 0;
    int oscHalf = 0;
    int halfCnt = 0;
    int riseQ[$];
    int expCount = 0;
    int expOvf = 0;
    int expCountS = 0;
    int expOvfS = 0;

    ring_vco_freq_counter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .win_len     (winLen),
        .osc         (osc),
        .vinit       (vinit),
        .busy        (busy),
        .count       (count),
        .count_valid (countValid),
        .count_ready (countReady),
        .overflow    (overflow)
    );

    ring_vco_freq_counter #(.CNT_W(4)) dutSat (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .win_len     (winLen),
        .osc         (osc),
        .vinit       (vinitS),
        .busy        (busyS),
        .count       (countS),
        .count_valid (countValidS),
        .count_ready (countReady),
        .overflow    (overflowS)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycNum <= cycNum + 1;

    // osc changes mid-cycle so the cycle in which each rise happens is unambiguous.
    always @(negedge clk) begin
        if (oscHalf > 0) begin
            halfCnt++;
            if (halfCnt >= oscHalf) begin
                halfCnt = 0;
                osc = ~osc;
                if (osc) riseQ.push_back(cycNum);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCnt++;
        if (observed !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int win, input int half, input bit expectClear,
                                 input bit readyAtStart, input bit pokeBusy);
        int s, firstLow, lowCnt, n, validK, lo, hi;
        bit gotValid;
        oscHalf = half;
        @(posedge clk); #1;
        start = 1'b1;
        winLen = 16'(win);
        countReady = readyAtStart;
        s = cycNum;
        riseQ.delete();
        firstLow = -1;
        lowCnt = 0;
        gotValid = 1'b0;
        validK = -1;
        for (int k = 1; k <= win + 200; k++) begin
            @(posedge clk); #1;
            start = (pokeBusy && k == 40);
            countReady = 1'b0;
            if (k == 1) begin
                winLen = 16'($urandom);
                checkOutput("busyRise", 32'(busy), 1);
                if (expectClear) checkOutput("validClear", 32'(countValid), 0);
            end
            if (!vinit) begin
                lowCnt++;
                if (firstLow < 0) firstLow = k;
            end
            if (countValid) begin
                gotValid = 1'b1;
                validK = k;
                break;
            end
        end
        start = 1'b0;
        checkOutput("validSeen", 32'(gotValid), 1);
        // Rises whose detection pulse falls inside the counting window.
        lo = s + 1 + INIT_C + SETTLE_C - SYNC_S;
        hi = lo + win - 1;
        n = 0;
        foreach (riseQ[i]) if (riseQ[i] >= lo && riseQ[i] <= hi) n++;
        expCount  = (n > 65535) ? 65535 : n;
        expOvf    = (n > 65535) ? 1 : 0;
        expCountS = (n > SAT_MAX) ? SAT_MAX : n;
        expOvfS   = (n > SAT_MAX) ? 1 : 0;
        checkOutput("latency", 32'(validK), 32'(2 + INIT_C + SETTLE_C + win));
        checkOutput("vinitLowCycles", 32'(lowCnt), INIT_C);
        checkOutput("vinitFirstLow", 32'(firstLow), 1);
        checkOutput("count", 32'(count), 32'(expCount));
        checkOutput("overflow", 32'(overflow), 32'(expOvf));
        checkOutput("satValid", 32'(countValidS), 1);
        checkOutput("satCount", 32'(countS), 32'(expCountS));
        checkOutput("satOverflow", 32'(overflowS), 32'(expOvfS));
        checkOutput("busyFall", 32'(busy), 0);
    endtask

    task automatic consumeResult(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput("holdValid", 32'(countValid), 1);
            checkOutput("holdCount", 32'(count), 32'(expCount));
        end
        countReady = 1'b1;
        @(posedge clk); #1;
        countReady = 1'b0;
        checkOutput("validDrop", 32'(countValid), 0);
        checkOutput("countKept", 32'(count), 32'(expCount));
        checkOutput("ovfKept", 32'(overflow), 32'(expOvf));
        checkOutput("satCountKept", 32'(countS), 32'(expCountS));
    endtask

    initial begin
        bit pending;
        int win, half;

        #12;
        checkOutput("rstVinit", 32'(vinit), 1);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstValid", 32'(countValid), 0);
        checkOutput("rstCount", 32'(count), 0);
        checkOutput("rstOverflow", 32'(overflow), 0);
        @(negedge clk) rst = 1'b0;

        // Reset while vinit is being driven low.
        oscHalf = 3;
        @(posedge clk); #1;
        start = 1'b1; winLen = 16'd500;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("vinitInInit", 32'(vinit), 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstInitVinit", 32'(vinit), 1);
        checkOutput("rstInitBusy", 32'(busy), 0);
        @(negedge clk) rst = 1'b0;

        // Reset in the middle of the counting window with osc toggling.
        @(posedge clk); #1;
        start = 1'b1; winLen = 16'd500;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (120) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("rstCountVinit", 32'(vinit), 1);
        checkOutput("rstCountBusy", 32'(busy), 0);
        checkOutput("rstCountValid", 32'(countValid), 0);
        checkOutput("rstCountValue", 32'(count), 0);
        @(negedge clk) rst = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        checkOutput("noPostValid", 32'(countValid), 0);
        checkOutput("noPostBusy", 32'(busy), 0);

        // Nominal 10 MHz osc, stray start during busy, then 50 cycles of backpressure.
        applyStimulus(1000, 5, 1'b0, 1'b0, 1'b1);
        consumeResult(50);

        applyStimulus(0, 3, 1'b0, 1'b0, 1'b0);
        consumeResult(2);

        // 25 MHz osc saturates the 4-bit instance; new start while result pending.
        applyStimulus(200, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(150, 4, 1'b1, 1'b0, 1'b0);
        consumeResult(1);

        // Result consumed in the same cycle a new start is accepted.
        applyStimulus(60, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(80, 3, 1'b1, 1'b1, 1'b0);
        consumeResult(0);

        pending = 1'b0;
        for (int it = 0; it < 12; it++) begin
            win  = $urandom_range(0, 300);
            half = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(2, 8);
            applyStimulus(win, half, pending, 1'(pending ? $urandom_range(0, 1) : 0), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                consumeResult($urandom_range(0, 5));
                pending = 1'b0;
            end else begin
                pending = 1'b1;
            end
        end
        if (pending) consumeResult(1);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
